// File: rtl/viterbi_ctrl.sv
// Frame sequencer for the rate-1/2 Viterbi datapath: ACS feed, reverse traceback, forward bit output.
// Define VITERBI_CTRL_STATS_EN to enable the completed-frame counter on frame_cnt.
module viterbi_ctrl #(
  parameter int FRAME_LEN = 16,
  parameter int ADDR_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        rx_pair_in,
  output logic [1:0]        rx_pair_out,
  output logic              acs_en,
  output logic              acs_init,
  output logic              mem_wr_en,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              tb_start,
  output logic              tb_en,
  input  logic              dec_bit_in,
  output logic              dec_valid,
  output logic              dec_bit,
  output logic              dec_last,
  input  logic              dec_ready,
  output logic              busy,
  output logic [7:0]        frame_cnt
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_LEN - 1);

  typedef enum logic [2:0] {IDLE, ACS, TB, TB_WAIT, OUT} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] step_q, step_d;
  logic [ADDR_W-1:0] outIdx_q, outIdx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] pendAddr_q, pendAddr_d;
  logic              pend_q, pend_d;
  logic [DEPTH-1:0]  bitBuf_q, bitBuf_d;
  logic [1:0]        pair_q, pair_d;
  logic              acsEn_q, acsEn_d;
  logic              acsInit_q, acsInit_d;
  logic              wrEn_q, wrEn_d;
  logic              rdEn_q, rdEn_d;
  logic              tbStart_q, tbStart_d;
  logic              decValid_q, decValid_d;
  logic              decBit_q, decBit_d;
  logic              decLast_q, decLast_d;
  logic              busy_q, busy_d;
  logic              accept;
  logic [ADDR_W-1:0] nextIdx;

  assign in_ready = (state_q == IDLE) || (state_q == ACS);
  assign accept   = in_valid && in_ready;
  assign nextIdx  = outIdx_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      step_q     <= '0;
      outIdx_q   <= '0;
      addr_q     <= '0;
      pendAddr_q <= '0;
      pend_q     <= 1'b0;
      bitBuf_q   <= '0;
      pair_q     <= 2'b00;
      acsEn_q    <= 1'b0;
      acsInit_q  <= 1'b0;
      wrEn_q     <= 1'b0;
      rdEn_q     <= 1'b0;
      tbStart_q  <= 1'b0;
      decValid_q <= 1'b0;
      decBit_q   <= 1'b0;
      decLast_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      outIdx_q   <= outIdx_d;
      addr_q     <= addr_d;
      pendAddr_q <= pendAddr_d;
      pend_q     <= pend_d;
      bitBuf_q   <= bitBuf_d;
      pair_q     <= pair_d;
      acsEn_q    <= acsEn_d;
      acsInit_q  <= acsInit_d;
      wrEn_q     <= wrEn_d;
      rdEn_q     <= rdEn_d;
      tbStart_q  <= tbStart_d;
      decValid_q <= decValid_d;
      decBit_q   <= decBit_d;
      decLast_q  <= decLast_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    outIdx_d   = outIdx_q;
    addr_d     = addr_q;
    pair_d     = pair_q;
    acsEn_d    = 1'b0;
    acsInit_d  = 1'b0;
    wrEn_d     = 1'b0;
    rdEn_d     = 1'b0;
    tbStart_d  = 1'b0;
    decValid_d = decValid_q;
    decBit_d   = decBit_q;
    decLast_d  = decLast_q;
    bitBuf_d   = bitBuf_q;
    // The traceback bit arrives one cycle after its read, so remember which address it belongs to.
    pend_d     = rdEn_q;
    pendAddr_d = addr_q;
    if (pend_q) begin
      bitBuf_d[pendAddr_q] = dec_bit_in;
    end

    case (state_q)
      IDLE, ACS: begin
        if (accept) begin
          pair_d    = rx_pair_in;
          acsEn_d   = 1'b1;
          wrEn_d    = 1'b1;
          addr_d    = step_q;
          acsInit_d = (step_q == '0);
          if (step_q == LAST) begin
            // Final write and first traceback read share the cycle and the address.
            step_d    = '0;
            rdEn_d    = 1'b1;
            tbStart_d = 1'b1;
            state_d   = TB;
          end else begin
            step_d  = step_q + 1'b1;
            state_d = ACS;
          end
        end
      end
      TB: begin
        if (addr_q == '0) begin
          state_d = TB_WAIT;
        end else begin
          addr_d = addr_q - 1'b1;
          rdEn_d = 1'b1;
        end
      end
      TB_WAIT: begin
        // Bit 0 is captured this very edge, so forward it straight from the input.
        state_d    = OUT;
        outIdx_d   = '0;
        decValid_d = 1'b1;
        decBit_d   = dec_bit_in;
        decLast_d  = 1'b0;
      end
      OUT: begin
        if (decValid_q && dec_ready) begin
          if (outIdx_q == LAST) begin
            state_d    = IDLE;
            outIdx_d   = '0;
            decValid_d = 1'b0;
            decBit_d   = 1'b0;
            decLast_d  = 1'b0;
          end else begin
            outIdx_d  = nextIdx;
            decBit_d  = bitBuf_q[nextIdx];
            decLast_d = (nextIdx == LAST);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign rx_pair_out = pair_q;
  assign acs_en      = acsEn_q;
  assign acs_init    = acsInit_q;
  assign mem_wr_en   = wrEn_q;
  assign mem_rd_en   = rdEn_q;
  assign tb_en       = rdEn_q;
  assign tb_start    = tbStart_q;
  assign mem_addr    = addr_q;
  assign dec_valid   = decValid_q;
  assign dec_bit     = decBit_q;
  assign dec_last    = decLast_q;
  assign busy        = busy_q;

`ifdef VITERBI_CTRL_STATS_EN
  logic [7:0] frameCnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frameCnt_q <= 8'd0;
    end else if (decValid_q && decLast_q && dec_ready) begin
      frameCnt_q <= frameCnt_q + 8'd1;
    end
  end

  assign frame_cnt = frameCnt_q;
`else
  assign frame_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_viterbi_ctrl.sv
// Self-checking bench for viterbi_ctrl: transaction-level model compared every cycle plus literal pins.
// Honours VITERBI_CTRL_STATS_EN for the expected frame_cnt.
module tb_viterbi_ctrl;

  localparam int N    = 4;
  localparam int AW   = 2;
  localparam int PW   = 2 * N;
  localparam int MAXC = 8192;
`ifdef VITERBI_CTRL_STATS_EN
  localparam int FINAL_CNT = 1;
`else
  localparam int FINAL_CNT = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    rx_pair_in = 2'b00;
  logic [1:0]    rx_pair_out;
  logic          acs_en, acs_init, mem_wr_en, mem_rd_en, tb_start, tb_en;
  logic [AW-1:0] mem_addr;
  logic          dec_bit_in = 1'b0;
  logic          dec_valid, dec_bit, dec_last;
  logic          dec_ready = 1'b1;
  logic          busy;
  logic [7:0]    frame_cnt;

  int tests = 0;
  int fails = 0;

  // Model state: phase 0 accepting, 1 decoding, 2 emitting.
  int         cyc = 0;
  int         phase = 0;
  int         stepM = 0;
  int         outK = 0;
  int         outStart = 0;
  int         framesDone = 0;
  int         lastAddr = 0;
  logic [1:0] lastPair = 2'b00;
  logic [N-1:0] tbBits = '0;
  logic [N-1:0] outBits = '0;
  bit sAcs[MAXC], sInit[MAXC], sWr[MAXC], sRd[MAXC], sStart[MAXC], sHas[MAXC];
  bit bitV[MAXC], bitD[MAXC];
  int sAddr[MAXC];

  int wrQ[$], rdQ[$], initQ[$], startQ[$], outQ[$];
  int acsCnt = 0;
  int lastPos = -1;

  viterbi_ctrl #(.FRAME_LEN(N), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rx_pair_in(rx_pair_in), .rx_pair_out(rx_pair_out), .acs_en(acs_en),
    .acs_init(acs_init), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr), .tb_start(tb_start), .tb_en(tb_en),
    .dec_bit_in(dec_bit_in), .dec_valid(dec_valid), .dec_bit(dec_bit),
    .dec_last(dec_last), .dec_ready(dec_ready), .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic checkSeq(input string name, input int q[$], input int n, input logic [15:0] e);
    checkOutput({name, "_len"}, q.size(), n);
    for (int i = 0; i < n && i < q.size(); i++) begin
      checkOutput(name, q[i], int'(e[4*i +: 4]));
    end
  endtask

  // Model: schedules the strobes, reads and outputs that each accept implies.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      phase = 0; stepM = 0; outK = 0; framesDone = 0; lastAddr = 0; lastPair = 2'b00;
      for (int i = cyc; i < cyc + 64 && i < MAXC; i++) begin
        sAcs[i] = 0; sInit[i] = 0; sWr[i] = 0; sRd[i] = 0; sStart[i] = 0; sHas[i] = 0;
        bitV[i] = 0;
      end
    end else begin
      int ph;
      int nx;
      ph = phase;
      nx = cyc + 1;
      if (ph == 2 && dec_ready) begin
        if (outK == N - 1) begin
          phase = 0;
          framesDone = (framesDone + 1) % 256;
        end else begin
          outK++;
        end
      end
      if (ph == 0 && in_valid && nx + N + 2 < MAXC) begin
        sAcs[nx] = 1; sWr[nx] = 1; sHas[nx] = 1; sAddr[nx] = stepM; sInit[nx] = (stepM == 0);
        lastPair = rx_pair_in;
        if (stepM == N - 1) begin
          for (int i = 0; i < N; i++) begin
            sRd[nx + i] = 1; sHas[nx + i] = 1; sAddr[nx + i] = N - 1 - i;
            bitV[nx + i + 1] = 1; bitD[nx + i + 1] = tbBits[N - 1 - i];
          end
          sStart[nx] = 1;
          outBits = tbBits;
          outStart = nx + N + 1;
          phase = 1;
          stepM = 0;
        end else begin
          stepM++;
        end
      end
      cyc = nx;
      if (phase == 1 && cyc == outStart) begin
        phase = 2;
        outK = 0;
      end
      if (cyc < MAXC && sHas[cyc]) lastAddr = sAddr[cyc];
    end
  end

  // Traceback responder: the decoded bit for a read is presented the cycle after it.
  initial forever begin
    @(posedge clk);
    #1;
    if (cyc < MAXC && bitV[cyc]) dec_bit_in = bitD[cyc];
    else dec_bit_in = 1'($urandom);
  end

  task automatic compareCycle();
    int expCnt;
    bit c;
    c = (cyc < MAXC);
`ifdef VITERBI_CTRL_STATS_EN
    expCnt = framesDone;
`else
    expCnt = 0;
`endif
    checkOutput("in_ready", int'(in_ready), int'(phase == 0));
    checkOutput("busy", int'(busy), int'(phase != 0 || stepM != 0));
    checkOutput("acs_en", int'(acs_en), int'(c && sAcs[cyc]));
    checkOutput("acs_init", int'(acs_init), int'(c && sInit[cyc]));
    checkOutput("mem_wr_en", int'(mem_wr_en), int'(c && sWr[cyc]));
    checkOutput("mem_rd_en", int'(mem_rd_en), int'(c && sRd[cyc]));
    checkOutput("tb_en", int'(tb_en), int'(c && sRd[cyc]));
    checkOutput("tb_start", int'(tb_start), int'(c && sStart[cyc]));
    checkOutput("mem_addr", int'(mem_addr), lastAddr);
    checkOutput("rx_pair_out", int'(rx_pair_out), int'(lastPair));
    checkOutput("dec_valid", int'(dec_valid), int'(phase == 2));
    if (phase == 2) begin
      checkOutput("dec_bit", int'(dec_bit), int'(outBits[outK]));
      checkOutput("dec_last", int'(dec_last), int'(outK == N - 1));
    end
    checkOutput("frame_cnt", int'(frame_cnt), expCnt);
    if (mem_wr_en) wrQ.push_back(int'(mem_addr));
    if (mem_rd_en) rdQ.push_back(int'(mem_addr));
    if (acs_init) initQ.push_back(int'(mem_addr));
    if (tb_start) startQ.push_back(int'(mem_addr));
    if (acs_en) acsCnt++;
    if (dec_valid && dec_ready) begin
      outQ.push_back(int'(dec_bit));
      if (dec_last) lastPos = outQ.size() - 1;
    end
  endtask

  initial forever begin
    @(negedge clk);
    compareCycle();
  end

  task automatic clearLog();
    wrQ.delete(); rdQ.delete(); initQ.delete(); startQ.delete(); outQ.delete();
    acsCnt = 0;
    lastPos = -1;
  endtask

  task automatic applyStimulus(input logic [PW-1:0] pairs, input bit gapped);
    for (int i = 0; i < N; i++) begin
      int waitCnt;
      bit taken;
      in_valid = 1'b1;
      rx_pair_in = pairs[2*i +: 2];
      waitCnt = 0;
      taken = 1'b0;
      while (!taken && waitCnt < 200) begin
        taken = in_ready;
        @(posedge clk);
        #1;
        waitCnt++;
      end
      checkOutput("accept", int'(taken), 1);
      if (!taken) begin
        in_valid = 1'b0;
        return;
      end
      if (gapped && i != N - 1) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (busy && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("idle_timeout", int'(busy), 0);
  endtask

  initial begin
    #400000;
    fails++;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    int n;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", int'(in_ready), 1);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_addr", int'(mem_addr), 0);
    checkOutput("reset_pair", int'(rx_pair_out), 0);
    checkOutput("reset_dec_valid", int'(dec_valid), 0);
    checkOutput("reset_frame_cnt", int'(frame_cnt), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic frame: pairs 01,10,11,00; traceback gives 1,0,1,1 for addrs 3,2,1,0.
    $display("[TB] basic frame");
    dec_ready = 1'b1;
    tbBits = 4'b1011;
    clearLog();
    applyStimulus({2'b00, 2'b11, 2'b10, 2'b01}, 1'b0);
    checkOutput("in_ready_after_last", int'(in_ready), 0);
    n = 1;
    while (!dec_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("latency", n, N + 2);
    waitIdle();
    checkSeq("wr_addrs", wrQ, 4, 16'h3210);
    checkSeq("init_addrs", initQ, 1, 16'h0000);
    checkSeq("rd_addrs", rdQ, 4, 16'h0123);
    checkSeq("start_addrs", startQ, 1, 16'h0003);
    checkSeq("out_bits", outQ, 4, 16'h1011);
    checkOutput("last_position", lastPos, 3);
    checkOutput("acs_count", acsCnt, 4);

    // Output stall with in_valid asserted during OUT.
    $display("[TB] output stall");
    tbBits = 4'b0110;
    dec_ready = 1'b0;
    clearLog();
    applyStimulus({2'b10, 2'b01, 2'b11, 2'b00}, 1'b0);
    n = 0;
    while (!dec_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("stall_out_reached", int'(dec_valid), 1);
    in_valid = 1'b1;
    rx_pair_in = 2'b10;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    checkOutput("stall_valid", int'(dec_valid), 1);
    checkOutput("stall_bit", int'(dec_bit), 0);
    checkOutput("stall_in_ready", int'(in_ready), 0);
    in_valid = 1'b0;
    dec_ready = 1'b1;
    waitIdle();
    checkSeq("stall_out_bits", outQ, 4, 16'h0110);
    checkOutput("stall_acs_count", acsCnt, 4);

    // Gapped input.
    $display("[TB] gapped input");
    tbBits = 4'b1100;
    clearLog();
    applyStimulus({2'b01, 2'b01, 2'b10, 2'b11}, 1'b1);
    waitIdle();
    checkSeq("gap_wr_addrs", wrQ, 4, 16'h3210);
    checkSeq("gap_out_bits", outQ, 4, 16'h1100);

    // Reset during traceback at mem_addr 1, then a fresh frame.
    $display("[TB] reset during traceback");
    tbBits = 4'b1111;
    clearLog();
    applyStimulus({2'b11, 2'b11, 2'b00, 2'b01}, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    checkOutput("pre_reset_addr", int'(mem_addr), 1);
    rst = 1'b1;
    #1;
    checkOutput("rst_in_ready", int'(in_ready), 1);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_rd_en", int'(mem_rd_en), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    checkOutput("no_partial_out", outQ.size(), 0);
    tbBits = 4'b0101;
    clearLog();
    applyStimulus({2'b00, 2'b10, 2'b01, 2'b11}, 1'b0);
    waitIdle();
    checkSeq("fresh_out_bits", outQ, 4, 16'h0101);

    // 256 more frames: 257 since reset.
    $display("[TB] frame counter run");
    for (int f = 0; f < 256; f++) begin
      tbBits = N'($urandom);
      applyStimulus(PW'($urandom), 1'b0);
    end
    waitIdle();
    checkOutput("frame_cnt_final", int'(frame_cnt), FINAL_CNT);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/viterbi_ctrl.md
Name: viterbi_ctrl

Overview:
Frame sequencer for the rate-1/2 Viterbi decoder datapath. Accepts received symbol pairs over a valid/ready handshake, feeds them one per cycle to the branch-metric/ACS stage, and writes survivor bits to trellis memory. It then runs a reverse-order traceback over the memory and re-orders the decoded bits into a buffer. Finally it emits those bits in forward order over a second valid/ready handshake.

Parameters:
FRAME_LEN, 16, symbol pairs per frame (>=2)
ADDR_W, 4, trellis memory address width; must satisfy 2**ADDR_W >= FRAME_LEN

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  rx_pair_in valid
in_ready  output  1  controller accepts a pair this cycle
rx_pair_in  input  2  received symbol pair
rx_pair_out  output  2  registered pair to branch-metric stage
acs_en  output  1  ACS step enable
acs_init  output  1  first step of frame; ACS loads initial path metrics
mem_wr_en  output  1  survivor write strobe
mem_rd_en  output  1  survivor read strobe (traceback)
mem_addr  output  ADDR_W  trellis memory address
tb_start  output  1  traceback begins at last trellis step
tb_en  output  1  traceback step enable
dec_bit_in  input  1  traceback decoded bit, valid 1 cycle after mem_rd_en
dec_valid  output  1  decoded bit valid
dec_bit  output  1  decoded bit
dec_last  output  1  final bit of frame
dec_ready  input  1  downstream accepts decoded bit
busy  output  1  state != IDLE
frame_cnt  output  8  completed-frame count (see Optional Feature)

Behaviour:
- Reset: asserting rst puts the block in state IDLE; in_ready=1; all other outputs 0. Counters, rx_pair_out, mem_addr and the bit buffer are cleared. Reset asserted mid-frame abandons the frame; no partial output is emitted.
- All outputs are registered except in_ready, which is decoded from state.
- States: IDLE, ACS, TB, TB_WAIT, OUT.
- IDLE / ACS (in_ready=1): an accept is in_valid&in_ready.
  - One cycle after each accept: rx_pair_out=accepted pair, acs_en=1, mem_wr_en=1, mem_addr=step index t (0..FRAME_LEN-1), acs_init=1 only when t=0.
  - With no accept, these strobes are 0 and rx_pair_out holds its value.
  - IDLE->ACS on the first accept. ACS->TB on the accept of step FRAME_LEN-1; in_ready=0 from the next cycle.
- TB (in_ready=0):
  - First TB cycle: tb_start=1, tb_en=1, mem_rd_en=1, mem_addr=FRAME_LEN-1. This coincides with the final ACS strobe cycle; write and read go to the same address, and memory is write-first.
  - Each following cycle: mem_addr decrements by 1 with mem_rd_en=tb_en=1.
  - After the cycle with mem_addr=0 -> TB_WAIT.
- Bit capture: dec_bit_in sampled one cycle after each mem_rd_en is stored at buf[address of that read]. TB_WAIT captures the bit for address 0, then -> OUT. Strobes are 0 in TB_WAIT.
- OUT:
  - dec_valid=1, dec_bit=buf[k], dec_last=(k==FRAME_LEN-1), with k starting at 0.
  - k advances only on dec_valid&dec_ready; outputs hold stable while dec_ready=0.
  - Handshake on k=FRAME_LEN-1 -> IDLE; dec_valid=0 next cycle, in_ready=1.
- in_valid during TB/TB_WAIT/OUT is ignored (not accepted); the source must hold it.
- Total latency, last accept to first dec_valid: FRAME_LEN+2 cycles.
- Throughput: one pair/cycle in ACS; frames do not overlap.

Optional Feature:
Macro VITERBI_CTRL_STATS_EN.
- Defined: frame_cnt increments by 1 on each dec_last&dec_valid&dec_ready handshake and wraps 255->0; reset to 0.
- Undefined: no counter logic; frame_cnt is tied to 0.

Test Plan:
- FRAME_LEN=4, pairs 01,10,11,00 on consecutive cycles -> acs_en high 4 cycles, mem_addr 0,1,2,3; acs_init only at addr 0; in_ready=0 after 4th accept.
- Traceback model returns bits 1,0,1,1 for addrs 3,2,1,0 -> mem_addr sequence 3,2,1,0 with tb_start at addr 3 only; output order 1,1,0,1 with dec_last on the 4th bit.
- dec_ready held 0 for 5 cycles in OUT -> dec_valid/dec_bit stable; no bit lost or duplicated; in_valid=1 during OUT is not accepted.
- Gapped input: in_valid toggling 1,0,1,0,... -> acs_en only on cycles after accepts; mem_addr contiguous 0..3.
- rst pulsed during TB (mem_addr=1) -> immediate IDLE with in_ready=1 and busy=0; a fresh frame then decodes correctly.
- VITERBI_CTRL_STATS_EN defined, 257 frames -> frame_cnt=1; undefined -> frame_cnt=0 throughout.
